// File: rtl/d_pipe_stage.sv
// One elastic pipeline stage: a data register plus its valid bit.
// Load takes priority over clear so a stage that hands its word on and
// receives a new one in the same cycle stays valid.
module d_pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             v
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;

    // Next-state: load new data, or drop the valid bit; data of an empty stage holds.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = d;
            valid_d = 1'b1;
        end else if (clear) begin
            valid_d = 1'b0;
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= RESET_VAL;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q = data_q;
    assign v = valid_q;

endmodule

// File: rtl/d_pipe_reg.sv
// WIDTH-bit, DEPTH-stage elastic register pipeline with valid/ready on both
// ends, a global enable hold, and bubble collapse. Stage 0 is the input end,
// stage DEPTH-1 drives q; qbar is taken from the same register.
module d_pipe_reg #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [WIDTH-1:0]           d,
    input  logic                       d_valid,
    output logic                       d_ready,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           qbar,
    output logic                       q_valid,
    input  logic                       q_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0]            adv;
    logic [DEPTH-1:0]            load;
    logic [DEPTH-1:0]            clear;
    logic [DEPTH-1:0][WIDTH-1:0] data;
    logic [DEPTH-1:0][WIDTH-1:0] din;
    logic                        in_xfer;
    logic                        out_xfer;
    logic [CNT_W-1:0]            count_d, count_q;

    // Advance chain, resolved from the output end back towards the input.
    always_comb begin
        adv            = '0;
        adv[DEPTH-1]   = enable && v[DEPTH-1] && q_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = enable && v[i] && (!v[i+1] || adv[i+1]);
        end
    end

    // Input side handshake; stage 0 frees up when empty or when it advances.
    always_comb begin
        d_ready  = enable && (!v[0] || adv[0]);
        in_xfer  = d_valid && d_ready;
        out_xfer = adv[DEPTH-1];
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign load[gi] = in_xfer;
                assign din[gi]  = d;
            end else begin : g_rest
                assign load[gi] = adv[gi-1];
                assign din[gi]  = data[gi-1];
            end
            assign clear[gi] = adv[gi] && !load[gi];

            d_pipe_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk   (clk),
                .rst   (rst),
                .load  (load[gi]),
                .clear (clear[gi]),
                .d     (din[gi]),
                .q     (data[gi]),
                .v     (v[gi])
            );
        end
    endgenerate

    // Occupancy: incremented on accept, decremented on deliver.
    always_comb begin
        count_d = count_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
    end

    // Occupancy register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign q       = data[DEPTH-1];
    assign qbar    = ~data[DEPTH-1];
    assign q_valid = v[DEPTH-1];
    assign count   = count_q;

endmodule

// File: tb/tb_d_pipe_reg.sv
// Scoreboard bench for d_pipe_reg (WIDTH=8, DEPTH=4, RESET_VAL=0).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_d_pipe_reg;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] d;
    logic       d_valid;
    logic       d_ready;
    logic [7:0] q;
    logic [7:0] qbar;
    logic       q_valid;
    logic       q_ready;
    logic [2:0] count;

    int         n_cmp;
    int         n_bad;
    logic [7:0] sb[$];
    logic       last_in;

    d_pipe_reg #(
        .WIDTH     (8),
        .DEPTH     (4),
        .RESET_VAL (8'h00)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .d       (d),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .q       (q),
        .qbar    (qbar),
        .q_valid (q_valid),
        .q_ready (q_ready),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: record transfers in the scoreboard, then check occupancy.
    task automatic tick();
        logic [7:0] exp;
        logic       rst_s;
        #1;
        last_in = 1'b0;
        if (!rst && d_valid && d_ready) begin
            sb.push_back(d);
            last_in = 1'b1;
            $display("in   d=%h", d);
        end
        if (!rst && q_valid && q_ready && enable) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL out_unexpected q=%h required no output", q);
            end else begin
                exp = sb.pop_front();
                $display("out  q=%h qbar=%h", q, qbar);
                if (q !== exp || qbar !== ~exp) begin
                    n_bad++;
                    $display("FAIL out_data q=%h qbar=%h required q=%h qbar=%h", q, qbar, exp, ~exp);
                end
            end
        end
        rst_s = rst;
        @(posedge clk);
        @(negedge clk);
        if (rst_s) sb.delete();
        n_cmp++;
        if (int'(count) != sb.size() || $isunknown(count)) begin
            n_bad++;
            $display("FAIL count count=%0d required %0d", count, sb.size());
        end
    endtask

    task automatic drain();
        enable  = 1'b1;
        d_valid = 1'b0;
        q_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (sb.size() == 0 && q_valid === 1'b0) break;
            tick();
        end
        n_cmp++;
        if (sb.size() != 0 || q_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL drain left=%0d q_valid=%b required 0 words and q_valid=0", sb.size(), q_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; d_valid = 1'b0; q_ready = 1'b0; d = 8'h00;
        tick();
        tick();
        n_cmp++;
        if (q !== 8'h00 || qbar !== 8'hFF || q_valid !== 1'b0 || count !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_state q=%h qbar=%h q_valid=%b count=%0d required 00 FF 0 0", q, qbar, q_valid, count);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (d_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_d_ready d_ready=%b required 1", d_ready);
        end
    endtask

    task automatic test_stream();
        logic [7:0] w [3] = '{8'hA5, 8'h3C, 8'h01};
        int lat;
        enable = 1'b1; q_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d_valid = 1'b1; d = w[k];
            tick();
        end
        d_valid = 1'b0;
        lat = 3;
        while (q_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        n_cmp++;
        if (lat != 4) begin
            n_bad++;
            $display("FAIL stream_latency latency=%0d required 4", lat);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (q_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL stream_consecutive word=%0d q_valid=%b required 1", k, q_valid);
            end
            tick();
        end
        n_cmp++;
        if (q_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_end q_valid=%b required 0", q_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] w [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        int idx;
        idx = 0;
        enable = 1'b1; q_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            d_valid = 1'b1; d = w[idx];
            tick();
            if (last_in) idx++;
        end
        #1;
        n_cmp++;
        if (idx != 4 || count !== 3'd4 || d_ready !== 1'b0 || q !== 8'h11 || q_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_full accepted=%0d count=%0d d_ready=%b q=%h q_valid=%b required 4 4 0 11 1",
                     idx, count, d_ready, q, q_valid);
        end
        q_ready = 1'b1; d = w[4];
        tick();
        n_cmp++;
        if (last_in !== 1'b1 || count !== 3'd4) begin
            n_bad++;
            $display("FAIL bp_swap accepted=%b count=%0d required 1 4", last_in, count);
        end
        drain();
    endtask

    task automatic test_bubble();
        int lat;
        enable = 1'b1; q_ready = 1'b0;
        d_valid = 1'b1; d = 8'h77;
        tick();
        d_valid = 1'b0;
        lat = 1;
        while (q_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        #1;
        n_cmp++;
        if (lat != 4 || q !== 8'h77 || count !== 3'd1 || d_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bubble latency=%0d q=%h count=%0d d_ready=%b required 4 77 1 1", lat, q, count, d_ready);
        end
        drain();
    endtask

    task automatic test_enable_freeze();
        enable = 1'b1; q_ready = 1'b0;
        d_valid = 1'b1; d = 8'h81; tick();
        d = 8'h82; tick();
        d_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        n_cmp++;
        if (q !== 8'h81 || q_valid !== 1'b1 || count !== 3'd2) begin
            n_bad++;
            $display("FAIL freeze_setup q=%h q_valid=%b count=%0d required 81 1 2", q, q_valid, count);
        end
        enable = 1'b0; d_valid = 1'b1; d = 8'h83; q_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (d_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL freeze_d_ready cycle=%0d d_ready=%b required 0", k, d_ready);
            end
            tick();
            n_cmp++;
            if (q !== 8'h81 || qbar !== 8'h7E || q_valid !== 1'b1 || count !== 3'd2) begin
                n_bad++;
                $display("FAIL freeze_hold cycle=%0d q=%h qbar=%h q_valid=%b count=%0d required 81 7E 1 2",
                         k, q, qbar, q_valid, count);
            end
        end
        enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (last_in) begin
                if (d == 8'h84) break;
                d = 8'h84;
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        enable = 1'b1; q_ready = 1'b0;
        d_valid = 1'b1;
        d = 8'h91; tick();
        d = 8'h92; tick();
        d = 8'h93; tick();
        rst = 1'b1; d = 8'h94; q_ready = 1'b1;
        tick();
        rst = 1'b0; d_valid = 1'b0;
        n_cmp++;
        if (count !== 3'd0 || q_valid !== 1'b0 || q !== 8'h00 || qbar !== 8'hFF) begin
            n_bad++;
            $display("FAIL rst_mid count=%0d q_valid=%b q=%h qbar=%h required 0 0 00 FF", count, q_valid, q, qbar);
        end
        for (int k = 0; k < 5; k++) tick();
        n_cmp++;
        if (q_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_discard q_valid=%b required 0", q_valid);
        end
    endtask

    task automatic test_back_to_back();
        d_valid = 1'b0;
        for (int k = 0; k < 120; k++) begin
            enable  = ($urandom_range(0, 7) != 0);
            q_ready = 1'($urandom_range(0, 1));
            if (!d_valid || last_in) begin
                d_valid = 1'($urandom_range(0, 1));
                d       = 8'($urandom);
            end
            tick();
        end
        drain();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; last_in = 1'b0;
        rst = 1'b1; enable = 1'b0; d = 8'h00; d_valid = 1'b0; q_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_enable_freeze();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
